instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 155 +++++++++++++++
 tb/tb_instr_sequencer.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetches 16-bit words, decodes the opcode and
// sequences ALU launch, register write-back, PC increment / relative jump and halt.
`timescale 1ns/1ps

module instr_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic        zero_flag,
  output logic [2:0]  alu_op,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic        reg_we,
  output logic        pc_en,
  output logic        jmp,
  output logic [15:0] offset,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    K_NOP,
    K_ALU,
    K_JMP,
    K_BEQZ,
    K_HALT,
    K_ILL
  } kind_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;
  logic        r_first;
  logic        r_active;
  kind_t       w_kind;
  logic        w_fetch_go;

  always_comb begin
    w_kind = K_ILL;
    case (r_ir[15:12])
      4'h0:          w_kind = K_NOP;
      4'h1, 4'h2, 4'h3,
      4'h4, 4'h5, 4'h6,
      4'h7:          w_kind = K_ALU;
      4'h8:          w_kind = K_JMP;
      4'h9:          w_kind = K_BEQZ;
      4'hF:          w_kind = K_HALT;
      default:       w_kind = K_ILL;
    endcase
  end

  // r_active holds off fetch requests until the first clock edge after reset release.
  assign w_fetch_go = (r_state == S_FETCH) && run && r_active && imem_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_FETCH;
      r_ir     <= '0;
      r_first  <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_active <= 1'b1;
      r_first  <= (r_state == S_DECODE);
      if (w_fetch_go) begin
        r_ir <= imem_rdata;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    imem_req  = 1'b0;
    alu_start = 1'b0;
    reg_we    = 1'b0;
    pc_en     = 1'b0;
    jmp       = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = run && r_active;
        if (w_fetch_go) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        case (w_kind)
          K_NOP: begin
            pc_en  = 1'b1;
            w_next = S_FETCH;
          end
          K_ILL: begin
            illegal = 1'b1;
            pc_en   = 1'b1;
            w_next  = S_FETCH;
          end
          K_HALT:  w_next = S_HALT;
          default: w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (w_kind)
          K_ALU: begin
            // A completion seen in the launch cycle itself is accepted.
            alu_start = r_first;
            if (alu_done) begin
              w_next = S_WB;
            end
          end
          K_JMP: begin
            jmp    = 1'b1;
            w_next = S_FETCH;
          end
          K_BEQZ: begin
            jmp    = zero_flag;
            pc_en  = !zero_flag;
            w_next = S_FETCH;
          end
          default: w_next = S_FETCH;
        endcase
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_en  = 1'b1;
        w_next = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign alu_op = r_ir[14:12];
  assign rd     = r_ir[11:8];
  assign rs     = r_ir[7:4];
  assign rt     = r_ir[3:0];
  assign offset = {{4{r_ir[11]}}, r_ir[11:0]};

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized
// instruction streams compared against a per-instruction behavioural model.
`timescale 1ns/1ps

module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        alu_start;
  logic        alu_done;
  logic        zero_flag;
  logic [2:0]  alu_op;
  logic [3:0]  rd, rs, rt;
  logic        reg_we, pc_en, jmp;
  logic [15:0] offset;
  logic        halted, illegal;

  int nvec = 0;
  int nerr = 0;

  instr_sequencer dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .alu_start(alu_start), .alu_done(alu_done), .zero_flag(zero_flag),
    .alu_op(alu_op), .rd(rd), .rs(rs), .rt(rt),
    .reg_we(reg_we), .pc_en(pc_en), .jmp(jmp), .offset(offset),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          gap;
    int          req_drop;
    int          pc_en_n;
    int          jmp_n;
    int          reg_we_n;
    int          start_n;
    int          ill_n;
    int          overlap_n;
    int          wb_pair_n;
    int          ill_pair_n;
    int          field_bad;
    bit          halt_seen;
    bit          timeout;
    logic [15:0] off;
    logic [14:0] fields;
  } obs_t;

  typedef struct {
    int          gap;
    int          pc_en_n;
    int          jmp_n;
    int          reg_we_n;
    int          start_n;
    int          ill_n;
    bit          halt;
    logic [15:0] off;
    logic [14:0] fields;
  } exp_t;

  // What one instruction should do, from the opcode table alone.
  function automatic exp_t model(input logic [15:0] ins, input int alu_lat, input bit zf);
    exp_t e;
    int   opc;
    int   v;
    e = '{default: 0};
    opc = int'(ins[15:12]);
    v = int'(ins[11:0]);
    if (v >= 2048) v = v - 4096;
    e.off    = 16'(v);
    e.fields = ins[14:0];
    if (opc == 0) begin
      e.pc_en_n = 1; e.gap = 2;
    end else if (opc <= 7) begin
      e.start_n = 1; e.reg_we_n = 1; e.pc_en_n = 1; e.gap = 4 + alu_lat;
    end else if (opc == 8) begin
      e.jmp_n = 1; e.gap = 3;
    end else if (opc == 9) begin
      if (zf) e.jmp_n = 1; else e.pc_en_n = 1;
      e.gap = 3;
    end else if (opc == 15) begin
      e.halt = 1; e.gap = 2;
    end else begin
      e.ill_n = 1; e.pc_en_n = 1; e.gap = 2;
    end
    return e;
  endfunction

  // Serves one fetch and one ALU op, recording the strobe activity until the next request.
  task automatic run_instr(input logic [15:0] ins, input int ack_lat, input int alu_lat,
                           input bit zf, output obs_t o);
    int done_in;
    bit fin;
    o = '{default: 0};
    zero_flag = zf;
    done_in = -1;
    fin = 1'b0;
    for (int i = 0; i <= ack_lat; i++) begin
      if (imem_req !== 1'b1) o.req_drop++;
      if (i == ack_lat) begin
        imem_ack = 1'b1;
        imem_rdata = ins;
      end
      @(negedge clk);
    end
    imem_ack = 1'b0;
    imem_rdata = 16'($urandom);
    for (int c = 1; c <= 200; c++) begin
      if (imem_req === 1'b1) begin o.gap = c; fin = 1'b1; break; end
      if (halted === 1'b1) begin o.gap = c; o.halt_seen = 1'b1; fin = 1'b1; break; end
      if (pc_en === 1'b1) o.pc_en_n++;
      if (jmp === 1'b1) begin o.jmp_n++; o.off = offset; end
      if (reg_we === 1'b1) o.reg_we_n++;
      if (illegal === 1'b1) o.ill_n++;
      if (pc_en === 1'b1 && jmp === 1'b1) o.overlap_n++;
      if (reg_we === 1'b1 && pc_en === 1'b1) o.wb_pair_n++;
      if (illegal === 1'b1 && pc_en === 1'b1) o.ill_pair_n++;
      if (alu_start === 1'b1) begin
        o.start_n++;
        o.fields = {alu_op, rd, rs, rt};
        done_in = alu_lat;
      end else if (o.start_n > 0 && {alu_op, rd, rs, rt} !== o.fields) begin
        o.field_bad++;
      end
      alu_done = (done_in == 0);
      if (done_in >= 0) done_in--;
      @(negedge clk);
    end
    alu_done = 1'b0;
    if (!fin) o.timeout = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; run = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    alu_done = 1'b0; zero_flag = 1'b0;
    #1;
    nvec++;
    if ({imem_req, alu_start, reg_we, pc_en, jmp, halted, illegal} !== 7'b0) begin
      nerr++;
      $display("FAIL reset_strobes: got %b want 0000000",
               {imem_req, alu_start, reg_we, pc_en, jmp, halted, illegal});
    end
    nvec++;
    if ({alu_op, rd, rs, rt, offset} !== 31'b0) begin
      nerr++;
      $display("FAIL reset_ir: got op=%0d rd=%0d rs=%0d rt=%0d off=%h want all 0",
               alu_op, rd, rs, rt, offset);
    end
    repeat (3) @(negedge clk);
    nvec++;
    if ({imem_req, halted} !== 2'b00) begin
      nerr++;
      $display("FAIL reset_hold: got req/halted=%b want 00", {imem_req, halted});
    end
    reset = 1'b1;
    #1;
    nvec++;
    if (imem_req !== 1'b0) begin
      nerr++;
      $display("FAIL release_req_early: got %b want 0", imem_req);
    end
    @(negedge clk);
    nvec++;
    if (imem_req !== 1'b1) begin
      nerr++;
      $display("FAIL release_first_req: got %b want 1", imem_req);
    end
  endtask

  task automatic test_alu();
    obs_t o;
    exp_t e;
    run_instr(16'h1123, 2, 3, 1'b0, o);
    e = model(16'h1123, 3, 1'b0);
    nvec++;
    if (o.timeout || o.req_drop != 0 || o.gap != e.gap) begin
      nerr++;
      $display("FAIL alu_timing: got gap=%0d drop=%0d to=%0d want gap=%0d drop=0 to=0",
               o.gap, o.req_drop, o.timeout, e.gap);
    end
    nvec++;
    if (o.start_n != 1 || o.fields !== 15'h1123) begin
      nerr++;
      $display("FAIL alu_start: got starts=%0d fields=%h want 1 fields=1123", o.start_n, o.fields);
    end
    nvec++;
    if (o.reg_we_n != 1 || o.pc_en_n != 1 || o.wb_pair_n != 1 || o.field_bad != 0) begin
      nerr++;
      $display("FAIL alu_wb: got we=%0d pc=%0d pair=%0d fbad=%0d want 1 1 1 0",
               o.reg_we_n, o.pc_en_n, o.wb_pair_n, o.field_bad);
    end
  endtask

  task automatic test_jmp();
    obs_t        o;
    exp_t        e;
    logic [15:0] prog [2];
    prog[0] = 16'h8FFE;
    prog[1] = 16'h8005;
    for (int k = 0; k < 2; k++) begin
      run_instr(prog[k], 1, 0, 1'b0, o);
      e = model(prog[k], 0, 1'b0);
      nvec++;
      if (o.jmp_n != 1 || o.pc_en_n != 0 || o.off !== e.off || o.gap != e.gap) begin
        nerr++;
        $display("FAIL jmp_%h: got jmp=%0d pc=%0d off=%h gap=%0d want 1 0 %h %0d",
                 prog[k], o.jmp_n, o.pc_en_n, o.off, o.gap, e.off, e.gap);
      end
    end
  endtask

  task automatic test_beqz();
    obs_t o;
    exp_t e;
    for (int z = 1; z >= 0; z--) begin
      run_instr(16'h9010, 0, 0, z[0], o);
      e = model(16'h9010, 0, z[0]);
      nvec++;
      if (o.jmp_n != e.jmp_n || o.pc_en_n != e.pc_en_n || o.gap != e.gap ||
          (e.jmp_n == 1 && o.off !== 16'h0010)) begin
        nerr++;
        $display("FAIL beqz_z%0d: got jmp=%0d pc=%0d off=%h gap=%0d want %0d %0d 0010 %0d",
                 z, o.jmp_n, o.pc_en_n, o.off, o.gap, e.jmp_n, e.pc_en_n, e.gap);
      end
    end
  endtask

  task automatic test_illegal();
    obs_t o;
    run_instr(16'hB000, 0, 0, 1'b0, o);
    nvec++;
    if (o.ill_n != 1 || o.ill_pair_n != 1 || o.pc_en_n != 1 || o.start_n != 0 || o.gap != 2) begin
      nerr++;
      $display("FAIL illegal: got ill=%0d pair=%0d pc=%0d start=%0d gap=%0d want 1 1 1 0 2",
               o.ill_n, o.ill_pair_n, o.pc_en_n, o.start_n, o.gap);
    end
    run_instr(16'h0ABC, 3, 0, 1'b1, o);
    nvec++;
    if (o.pc_en_n != 1 || o.ill_n != 0 || o.jmp_n != 0 || o.gap != 2 || o.req_drop != 0) begin
      nerr++;
      $display("FAIL nop: got pc=%0d ill=%0d jmp=%0d gap=%0d drop=%0d want 1 0 0 2 0",
               o.pc_en_n, o.ill_n, o.jmp_n, o.gap, o.req_drop);
    end
  endtask

  task automatic test_run_drop();
    obs_t o;
    run = 1'b0;
    #1;
    nvec++;
    if (imem_req !== 1'b0) begin
      nerr++;
      $display("FAIL run_drop_req: got %b want 0", imem_req);
    end
    imem_ack = 1'b1;
    imem_rdata = 16'h8123;
    @(negedge clk);
    imem_ack = 1'b0;
    run = 1'b1;
    #1;
    nvec++;
    if (imem_req !== 1'b1) begin
      nerr++;
      $display("FAIL run_drop_noload: got req=%b want 1", imem_req);
    end
    run_instr(16'h8010, 0, 0, 1'b0, o);
    nvec++;
    if (o.jmp_n != 1 || o.off !== 16'h0010) begin
      nerr++;
      $display("FAIL run_drop_next: got jmp=%0d off=%h want 1 0010", o.jmp_n, o.off);
    end
  endtask

  task automatic test_random();
    obs_t        o;
    exp_t        e;
    logic [15:0] ins;
    int          al, ak;
    bit          zf;
    for (int k = 0; k < 40; k++) begin
      ins = 16'($urandom);
      ins[15:12] = 4'($urandom_range(0, 14));
      al = int'($urandom_range(0, 4));
      ak = int'($urandom_range(0, 3));
      zf = 1'($urandom_range(0, 1));
      run_instr(ins, ak, al, zf, o);
      e = model(ins, al, zf);
      nvec++;
      if (o.timeout || o.halt_seen || o.req_drop != 0 || o.gap != e.gap) begin
        nerr++;
        $display("FAIL rnd_timing %h: got gap=%0d drop=%0d to=%0d hlt=%0d want gap=%0d",
                 ins, o.gap, o.req_drop, o.timeout, o.halt_seen, e.gap);
      end
      nvec++;
      if (o.pc_en_n != e.pc_en_n || o.jmp_n != e.jmp_n || o.reg_we_n != e.reg_we_n ||
          o.start_n != e.start_n || o.ill_n != e.ill_n || o.overlap_n != 0) begin
        nerr++;
        $display("FAIL rnd_strobes %h zf=%0d: got pc=%0d jmp=%0d we=%0d st=%0d ill=%0d ovl=%0d want %0d %0d %0d %0d %0d 0",
                 ins, zf, o.pc_en_n, o.jmp_n, o.reg_we_n, o.start_n, o.ill_n, o.overlap_n,
                 e.pc_en_n, e.jmp_n, e.reg_we_n, e.start_n, e.ill_n);
      end
      if (e.jmp_n == 1) begin
        nvec++;
        if (o.off !== e.off) begin
          nerr++;
          $display("FAIL rnd_offset %h: got %h want %h", ins, o.off, e.off);
        end
      end
      if (e.start_n == 1) begin
        nvec++;
        if (o.fields !== e.fields || o.field_bad != 0 || o.wb_pair_n != 1) begin
          nerr++;
          $display("FAIL rnd_alu %h: got fields=%h fbad=%0d pair=%0d want %h 0 1",
                   ins, o.fields, o.field_bad, o.wb_pair_n, e.fields);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    imem_ack = 1'b1;
    imem_rdata = 16'h1456;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    nvec++;
    if (alu_start !== 1'b1) begin
      nerr++;
      $display("FAIL mid_start: got %b want 1", alu_start);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    alu_done = 1'b1;
    #1;
    nvec++;
    if ({imem_req, alu_start, reg_we, pc_en, jmp, halted, illegal, alu_op, rd} !== 14'b0) begin
      nerr++;
      $display("FAIL mid_abort: got strobes=%b op=%0d rd=%0d want 0",
               {imem_req, alu_start, reg_we, pc_en, jmp, halted, illegal}, alu_op, rd);
    end
    run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (reg_we !== 1'b0 || pc_en !== 1'b0 || imem_req !== 1'b0 || alu_start !== 1'b0) bad++;
    end
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL mid_no_wb: got %0d strobe cycles want 0", bad);
    end
    alu_done = 1'b0;
    run = 1'b1;
    #1;
    nvec++;
    if (imem_req !== 1'b1) begin
      nerr++;
      $display("FAIL mid_refetch: got %b want 1", imem_req);
    end
  endtask

  task automatic test_halt();
    obs_t o;
    int   bad;
    run_instr(16'hF000, 1, 0, 1'b0, o);
    nvec++;
    if (!o.halt_seen || o.gap != 2 || o.pc_en_n != 0 || o.jmp_n != 0) begin
      nerr++;
      $display("FAIL halt_enter: got hlt=%0d gap=%0d pc=%0d jmp=%0d want 1 2 0 0",
               o.halt_seen, o.gap, o.pc_en_n, o.jmp_n);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (halted !== 1'b1 || imem_req !== 1'b0 || pc_en !== 1'b0 || jmp !== 1'b0) bad++;
    end
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL halt_hold: got %0d bad cycles of 20 want 0", bad);
    end
    reset = 1'b0;
    #1;
    nvec++;
    if (halted !== 1'b0) begin
      nerr++;
      $display("FAIL halt_reset: got halted=%b want 0", halted);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    nvec++;
    if (imem_req !== 1'b1 || halted !== 1'b0) begin
      nerr++;
      $display("FAIL halt_resume: got req=%b halted=%b want 1 0", imem_req, halted);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_jmp();
    test_beqz();
    test_illegal();
    test_run_drop();
    test_random();
    test_reset_mid();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
